display_nmux: RTL

//  Parametrised time-multiplexed driver for N common-anode 7-segment digits (a-g+dp).

---
 rtl/display_nmux_if.sv | 18 +
 rtl/display_nmux.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/display_nmux_if.sv
// Load-side bus between the segment decoder (master) and the digit buffers (slave).
// Latency: n/a (wires only). Backpressure: busy high means loads are dropped, no ack.
interface display_nmux_if #(
    parameter int NDIG  = 4,
    parameter int SEG_W = 8
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic             clear;
    logic             load;
    logic [IW-1:0]    bufdestino;
    logic [SEG_W-1:0] datai;
    logic             busy;
    logic             load_err;

    modport master (output clear, load, bufdestino, datai, input busy, load_err);
    modport slave  (input clear, load, bufdestino, datai, output busy, load_err);
endinterface

// File: rtl/display_nmux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with anti-ghost blanking and sequenced clear.
// Latency: buffer write visible on segments 1 clock later when that digit is active; outputs registered.
// Backpressure: loads dropped while busy (clear running); optional blink via DISPLAY_BLINK_EN.
module display_nmux #(
    parameter int              NDIG      = 4,
    parameter int              SEG_W     = 8,
    parameter int              SCAN_DIV  = 16384,
    parameter int              BLANK_CYC = 64,
    parameter logic [SEG_W-1:0] CLEAR_PAT = 8'b11111110
) (
    input  logic               reloj,
    input  logic               reset_n,
`ifdef DISPLAY_BLINK_EN
    input  logic [NDIG-1:0]    blink_mask,
`endif
    display_nmux_if.slave      bus,
    output logic [SEG_W-1:0]   disp_7seg_a_g_dp,
    output logic [NDIG-1:0]    anodos
);
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = $clog2(SCAN_DIV);
    localparam int LAST = NDIG - 1;
    localparam int PMAX = SCAN_DIV - 1;

    localparam logic [IW-1:0] IDX_MAX  = LAST[IW-1:0];
    localparam logic [IW:0]   NDIG_W   = NDIG[IW:0];
    localparam logic [PW-1:0] SCAN_MAX = PMAX[PW-1:0];
    localparam logic [PW-1:0] BLANK_W  = BLANK_CYC[PW-1:0];

    typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    idx;
    logic [PW-1:0]    pre;
    logic             busy_q;
    logic             load_err_q;
    logic [SEG_W-1:0] buff [NDIG];

    logic             pre_wrap;
    logic             load_hit;
    logic             load_ok;
    logic             load_bad;
    logic             clr_wr;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic [SEG_W-1:0] wr_dat;
    logic [SEG_W-1:0] seg_nx;
    logic [NDIG-1:0]  an_nx;
    logic             blank_seg;

`ifdef DISPLAY_BLINK_EN
    logic [23:0]      blink_cnt;

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 24'd1;
        end
    end

    assign blank_seg = blink_mask[idx] & blink_cnt[23];
`else
    assign blank_seg = 1'b0;
`endif

    assign pre_wrap = (pre == SCAN_MAX);

    // clear wins over everything on its edge, including a coincident load
    assign load_hit = (state == S_IDLE) && !bus.clear && bus.load;
    assign load_ok  = load_hit && ({1'b0, bus.bufdestino} < NDIG_W);
    assign load_bad = load_hit && ({1'b0, bus.bufdestino} >= NDIG_W);
    assign clr_wr   = (state == S_CLEAR) && !bus.clear;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_dat = '0;
        if (clr_wr) begin
            wr_en  = 1'b1;
            wr_idx = ptr;
            wr_dat = CLEAR_PAT;
        end else if (load_ok) begin
            wr_en  = 1'b1;
            wr_idx = bus.bufdestino;
            wr_dat = bus.datai;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset_n && wr_en) begin
            buff[wr_idx] <= wr_dat;
        end
    end

    always_comb begin
        an_nx  = '1;
        seg_nx = '1;
        if (pre >= BLANK_W) begin
            an_nx[idx] = 1'b0;
            if (!blank_seg) begin
                seg_nx = buff[idx];
            end
        end
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_CLEAR;
            ptr              <= '0;
            idx              <= '0;
            pre              <= '0;
            busy_q           <= 1'b1;
            load_err_q       <= 1'b0;
            disp_7seg_a_g_dp <= '1;
            anodos           <= '1;
        end else begin
            pre <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            load_err_q       <= load_bad;
            disp_7seg_a_g_dp <= seg_nx;
            anodos           <= an_nx;

            if (bus.clear) begin
                state  <= S_CLEAR;
                ptr    <= '0;
                busy_q <= 1'b1;
            end else begin
                case (state)
                    S_CLEAR: begin
                        if (ptr == IDX_MAX) begin
                            state  <= S_IDLE;
                            ptr    <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    default: begin
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.load_err = load_err_q;
endmodule
